mem_arbiter: RTL and testbench

- Shares the single main-memory word port between the I-cache refill path and the D-cache refill/writeback path.
- Each requester asks for a whole line. The arbiter runs the line as a burst of LINE_WORDS single-word transactions and signals completion.
- Its busy output feeds the miss input of the pipeline hazard unit. That input freezes all pipeline registers while a line transfer is outstanding.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default line geometry for the main-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BURST = 2'd1,
    D_BURST = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned IDX_W      = $clog2(LINE_WORDS);
  localparam int unsigned BYTE_OFF   = 2;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the main-memory word port between I-cache refills
// and D-cache refills/writebacks, running each line as a LINE_WORDS-word burst.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = mem_arbiter_pkg::LINE_WORDS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic                          i_rvalid,
  output logic [DATA_W-1:0]             i_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] i_widx,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          d_rvalid,
  output logic [DATA_W-1:0]             d_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] d_widx,
  output logic                          d_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ready,
  output logic                          busy
);

  localparam int unsigned WIDX_W      = $clog2(LINE_WORDS);
  localparam int unsigned BYTE_STRIDE = DATA_W / 8;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(LINE_WORDS - 1);

  arb_state_t          state, next_state;
  logic [WIDX_W-1:0]   idx;
  logic [ADDR_W-1:0]   base;
  logic                we_q;
  owner_t              owner;
  owner_t              last_grant;
  owner_t              grant;
  logic                in_burst;
  logic                word_done;

  // On a tie the side that did not win last time is served.
  always_comb begin
    grant = OWN_D;
    if (i_req && d_req)
      grant = (last_grant == OWN_D) ? OWN_I : OWN_D;
    else if (i_req)
      grant = OWN_I;
  end

  assign in_burst  = (state == I_BURST) || (state == D_BURST);
  assign word_done = in_burst && mem_ready;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (i_req || d_req)
          next_state = (grant == OWN_I) ? I_BURST : D_BURST;
      end
      I_BURST, D_BURST: begin
        if (mem_ready && idx == LAST_IDX)
          next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      base       <= '0;
      we_q       <= 1'b0;
      owner      <= OWN_I;
      last_grant <= OWN_D;
    end else begin
      state <= next_state;
      if (state == IDLE && (i_req || d_req)) begin
        base       <= (grant == OWN_I) ? i_addr : d_addr;
        we_q       <= (grant == OWN_D) ? d_we : 1'b0;
        idx        <= '0;
        owner      <= grant;
        last_grant <= grant;
      end else if (word_done) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    i_widx    = '0;
    i_done    = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_widx    = '0;
    d_done    = 1'b0;
    if (in_burst) begin
      mem_req  = 1'b1;
      mem_addr = base + ADDR_W'(idx) * ADDR_W'(BYTE_STRIDE);
      if (owner == OWN_I) begin
        i_widx   = idx;
        i_rvalid = mem_ready;
        i_rdata  = mem_ready ? mem_rdata : '0;
      end else begin
        d_widx = idx;
        mem_we = we_q;
        if (we_q) begin
          mem_wdata = d_wdata;
        end else begin
          d_rvalid = mem_ready;
          d_rdata  = mem_ready ? mem_rdata : '0;
        end
      end
    end else if (state == DONE) begin
      i_done = (owner == OWN_I);
      d_done = (owner == OWN_D);
    end
  end

  // Gated by rst_n so the hazard unit sees no miss while reset is held.
  assign busy = rst_n && ((state != IDLE) || i_req || d_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default 32-bit, 4-word lines).
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [1:0]  i_widx;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [1:0]  d_widx;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_widx(i_widx), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_widx(d_widx), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // D-cache supplies its writeback word for the index it is shown.
  assign d_wdata = 32'hD000 + 32'(d_widx);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one line from the first burst cycle through the done cycle; the owner
  // drops its request in the done cycle.
  task automatic do_burst(input bit is_d, input bit we, input logic [31:0] base,
                          input int stall_w, input int stall_n);
    logic        exp_we;
    logic [31:0] exp_wd;
    logic [31:0] got_rd;
    bit          rdy;
    for (int w = 0; w < 4; w++) begin
      for (int s = 0; s <= ((w == stall_w) ? stall_n : 0); s++) begin
        rdy       = !((w == stall_w) && (s < stall_n));
        mem_ready = rdy;
        mem_rdata = rdy ? (32'hA0 + 32'(w)) : 32'hBAD0_BAD0;
        #1;
        exp_we = is_d && we;
        exp_wd = exp_we ? (32'hD000 + 32'(w)) : 32'h0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== base + 32'(4 * w) ||
            mem_we !== exp_we || mem_wdata !== exp_wd) begin
          errors++;
          $display("FAIL burst_mem w=%0d s=%0d: req=%b addr=%h we=%b wdata=%h, want req=1 addr=%h we=%b wdata=%h",
                   w, s, mem_req, mem_addr, mem_we, mem_wdata, base + 32'(4 * w), exp_we, exp_wd);
        end
        checks++;
        if (i_rvalid !== (!is_d && rdy) || d_rvalid !== (is_d && !we && rdy) ||
            i_widx !== (is_d ? 2'd0 : 2'(w)) || d_widx !== (is_d ? 2'(w) : 2'd0) ||
            i_done !== 1'b0 || d_done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL burst_side w=%0d s=%0d: irv=%b drv=%b iw=%0d dw=%0d idn=%b ddn=%b busy=%b, want irv=%b drv=%b widx=%0d no done busy=1",
                   w, s, i_rvalid, d_rvalid, i_widx, d_widx, i_done, d_done, busy,
                   (!is_d && rdy), (is_d && !we && rdy), w);
        end
        if (rdy && !(is_d && we)) begin
          got_rd = is_d ? d_rdata : i_rdata;
          checks++;
          if (got_rd !== 32'hA0 + 32'(w)) begin
            errors++;
            $display("FAIL burst_rdata w=%0d: got %h want %h", w, got_rd, 32'hA0 + 32'(w));
          end
        end
        #1;
        tick();
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || i_done !== !is_d || d_done !== is_d || busy !== 1'b1 ||
        i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: req=%b idone=%b ddone=%b busy=%b irv=%b drv=%b, want req=0 idone=%b ddone=%b busy=1",
               mem_req, i_done, d_done, busy, i_rvalid, d_rvalid, !is_d, is_d);
    end
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic expect_idle(input string name, input bit exp_busy);
    checks++;
    if (mem_req !== 1'b0 || busy !== exp_busy || i_done !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: req=%b busy=%b idone=%b ddone=%b, want req=0 busy=%b no done",
               name, mem_req, busy, i_done, d_done, exp_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    checks++;
    if ({mem_req, mem_we, i_rvalid, d_rvalid, i_done, d_done, busy} !== 7'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || i_widx !== 2'd0 || d_widx !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h irv=%b drv=%b busy=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, i_rvalid, d_rvalid, busy);
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    expect_idle("reset_idle", 1'b0);
  endtask

  task automatic test_lone_i();
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    expect_idle("lone_i_arb_cycle", 1'b1);
    tick();
    do_burst(1'b0, 1'b0, 32'h100, -1, 0);
    expect_idle("lone_i_after", 1'b0);
  endtask

  task automatic test_d_writeback();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000;
    tick();
    do_burst(1'b1, 1'b1, 32'h2000, -1, 0);
    expect_idle("d_wb_after", 1'b0);
  endtask

  task automatic test_tie();
    // Lone D last, so the tie goes to I.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h300; d_addr = 32'h400;
    tick();
    do_burst(1'b0, 1'b0, 32'h300, -1, 0);
    expect_idle("tie_gap", 1'b1);
    tick();
    do_burst(1'b1, 1'b0, 32'h400, -1, 0);
    expect_idle("tie_after", 1'b0);
    // Lone I leaves last_grant=I; the next tie goes to D.
    i_req = 1'b1; i_addr = 32'h500;
    tick();
    do_burst(1'b0, 1'b0, 32'h500, -1, 0);
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h600; d_addr = 32'h700;
    tick();
    do_burst(1'b1, 1'b0, 32'h700, -1, 0);
    expect_idle("tie2_gap", 1'b1);
    tick();
    do_burst(1'b0, 1'b0, 32'h600, -1, 0);
    expect_idle("tie2_after", 1'b0);
  endtask

  task automatic test_backpressure();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000;
    tick();
    do_burst(1'b1, 1'b1, 32'h3000, 2, 3);
    i_req = 1'b1; i_addr = 32'h3100;
    tick();
    do_burst(1'b0, 1'b0, 32'h3100, 1, 2);
    expect_idle("stall_after", 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hA0;
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h804 || d_widx !== 2'd1) begin
      errors++;
      $display("FAIL mid_burst_word1: req=%b addr=%h widx=%0d, want req=1 addr=00000804 widx=1",
               mem_req, mem_addr, d_widx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || d_done !== 1'b0 || d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_burst_reset: req=%b busy=%b ddone=%b drv=%b, want all 0",
               mem_req, busy, d_done, d_rvalid);
    end
    d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    expect_idle("post_reset_idle", 1'b0);
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    do_burst(1'b0, 1'b0, 32'h100, -1, 0);
    expect_idle("post_reset_after", 1'b0);
  endtask

  initial begin
    test_reset();
    test_lone_i();
    test_d_writeback();
    test_tie();
    test_backpressure();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
